control_sequencer: RTL and testbench
====================================

# control_sequencer

Hardwired control unit that steps the CPU through fetch and execute phases and drives every datapath strobe, including the gra/grb/grc/rIN/rOUT/baOUT lines consumed by the register-select stage. It sits directly upstream of the register-select logic and the bus/ALU datapath. It takes the opcode field of the instruction register, the branch condition flag and a memory-ready handshake, and produces one set of strobes per step. Only sequential state is a 3-bit step counter plus a halted flag.

## Interface
- ALU_W, 4, width of alu_op
- clock  in  1  rising-edge system clock
- reset_n  in  1  asynchronous active-low reset
- opcode  in  5  IR[31:27]; valid from T3 onward
- con_ff  in  1  branch-condition flip-flop output
- mem_ready  in  1  memory completes current read/write this cycle
- gra, grb, grc  out  1 each  register-field select strobes
- rIN, rOUT, baOUT  out  1 each  register write / read / base-address read
- pc_out, pc_in, inc_pc  out  1 each  PC bus drive / load / increment
- mar_in, mdr_in, mdr_out, ir_in  out  1 each  MAR, MDR, IR strobes
- read, write  out  1 each  memory request
- y_in, z_in, z_lo_out, c_out, con_in  out  1 each  ALU operand/result, immediate drive, condition latch
- alu_op  out  ALU_W  ADD=0000, SUB=0001, AND=0010, OR=0011; 0000 when unused
- run  out  1  high unless halted or in reset
- illegal  out  1  one-cycle pulse on undefined opcode

## Operation
- Step counter T0..T7; every step not stalled advances by 1; last step of an instruction returns to T0.
- Outputs decoded from (step, opcode, con_ff, mem_ready); all unlisted strobes 0.
- Fetch, all opcodes: T0 pc_out, mar_in, inc_pc. T1 read, mdr_in; hold T1 while mem_ready=0. T2 mdr_out, ir_in.
- add 00011 / sub 00100 / and 00101 / or 00110: T3 grb, rOUT, y_in. T4 grc, rOUT, z_in, alu_op per opcode. T5 z_lo_out, gra, rIN. Last = T5.
- addi 01100: T3 grb, rOUT, y_in. T4 c_out, z_in, ADD. T5 z_lo_out, gra, rIN.
- ldi 00001: T3 grb, baOUT, y_in. T4 c_out, z_in, ADD. T5 z_lo_out, gra, rIN.
- ld 00000: T3-T4 as ldi. T5 z_lo_out, mar_in. T6 read, mdr_in; hold while mem_ready=0. T7 mdr_out, gra, rIN.
- st 00010: T3-T5 as ld. T6 gra, rOUT, mdr_in, read=0. T7 write; hold while mem_ready=0.
- br 10010: T3 gra, rOUT, con_in. T4 pc_out, y_in. T5 c_out, z_in, ADD. T6 z_lo_out and pc_in only if con_ff=1; else no strobes. Last = T6.
- jr 10011: T3 gra, rOUT, pc_in. Last = T3.
- nop 11010: T3 no strobes. Last = T3.
- halt 11011: at T3 set halted; run=0; counter frozen, all strobes 0 until reset.
- Any other opcode: illegal=1 during T3, treated as nop.
- Strobes are mutually exclusive on the bus: at most one of rOUT/baOUT/pc_out/mdr_out/z_lo_out/c_out per step.

## Timing
- Reset (reset_n=0, async): step=T0, halted=0, every output 0 incl. run. First rising edge after release executes T0; run=1 from release.
- Reset mid-instruction: read/write and all strobes drop immediately, no completion of the pending access.
- Latency with mem_ready=1: jr/nop 4 cycles, ALU/addi/ldi 6, br 7, ld/st 8; each mem_ready=0 cycle in T1/T6(ld)/T7(st) adds one.
- During a stall, all strobes of the stalled step stay asserted and stable.
- mem_ready outside a memory step is ignored.
- con_ff sampled combinationally only in br T6; con_in precedes it by 3 cycles.
- Counter never exceeds T7; no wrap without returning through the last-step rule.

## Test plan
- Reset then add (opcode 00011), mem_ready=1 -> T0..T5 strobes exactly as listed, alu_op=0000 at T4, back to T0 at cycle 7; run=1.
- ld with mem_ready=0 for 3 cycles in T6 -> read and mdr_in held 3 extra cycles, total 11 cycles, rIN only at T7.
- br with con_ff=0 then con_ff=1 -> pc_in absent in first, single pc_in pulse at T6 in second.
- Opcode 11111 -> illegal pulse exactly one cycle at T3, no other strobes, next fetch at cycle 5.
- halt -> run=0 from cycle after T3, all outputs 0 for 20 cycles; reset_n pulse restores run=1 and fetch.
- reset_n asserted mid-T7 of st with write=1 -> write drops same cycle, step=T0 after release.

Source files
------------

// File: rtl/control_sequencer_if.sv
// Control bus between the hardwired sequencer and the register-select / datapath stages.
// The master side is the sequencer; the slave side is the datapath that supplies opcode and status.
interface control_sequencer_if #(
   parameter int ALU_W = 4
);
   logic [4:0]       opcode;
   logic             con_ff;
   logic             mem_ready;

   logic             gra;
   logic             grb;
   logic             grc;
   logic             rIN;
   logic             rOUT;
   logic             baOUT;
   logic             pc_out;
   logic             pc_in;
   logic             inc_pc;
   logic             mar_in;
   logic             mdr_in;
   logic             mdr_out;
   logic             ir_in;
   logic             read;
   logic             write;
   logic             y_in;
   logic             z_in;
   logic             z_lo_out;
   logic             c_out;
   logic             con_in;
   logic [ALU_W-1:0] alu_op;
   logic             run;
   logic             illegal;

   modport master (
      input  opcode, con_ff, mem_ready,
      output gra, grb, grc, rIN, rOUT, baOUT,
      output pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in,
      output read, write, y_in, z_in, z_lo_out, c_out, con_in,
      output alu_op, run, illegal
   );

   modport slave (
      output opcode, con_ff, mem_ready,
      input  gra, grb, grc, rIN, rOUT, baOUT,
      input  pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in,
      input  read, write, y_in, z_in, z_lo_out, c_out, con_in,
      input  alu_op, run, illegal
   );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer: a T0..T7 step counter plus a halted flag,
// with every datapath strobe decoded combinationally from (step, opcode, con_ff, mem_ready).
module control_sequencer #(
   parameter int ALU_W = 4
) (
   input logic                 clock,
   input logic                 reset_n,
   control_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      T0, T1, T2, T3, T4, T5, T6, T7
   } step_t;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_BR   = 5'b10010;
   localparam logic [4:0] OP_JR   = 5'b10011;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(0);
   localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(1);
   localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(2);
   localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(3);

   typedef struct packed {
      logic             gra;
      logic             grb;
      logic             grc;
      logic             r_in;
      logic             r_out;
      logic             ba_out;
      logic             pc_out;
      logic             pc_in;
      logic             inc_pc;
      logic             mar_in;
      logic             mdr_in;
      logic             mdr_out;
      logic             ir_in;
      logic             read;
      logic             write;
      logic             y_in;
      logic             z_in;
      logic             z_lo_out;
      logic             c_out;
      logic             con_in;
      logic             illegal;
      logic [ALU_W-1:0] alu_op;
   } ctrl_t;

   step_t step;
   logic  halted;
   ctrl_t ctrl;
   ctrl_t ctrl_gated;
   logic  last_step;
   logic  stall;
   logic  is_alu_rr;

   assign is_alu_rr = (bus.opcode == OP_ADD) || (bus.opcode == OP_SUB) ||
                      (bus.opcode == OP_AND) || (bus.opcode == OP_OR);

   // Step/opcode decode; any combination not explicitly listed ends the instruction.
   always_comb begin
      ctrl      = '0;
      last_step = 1'b0;
      stall     = 1'b0;
      case (step)
         T0: begin
            ctrl.pc_out = 1'b1;
            ctrl.mar_in = 1'b1;
            ctrl.inc_pc = 1'b1;
         end
         T1: begin
            ctrl.read   = 1'b1;
            ctrl.mdr_in = 1'b1;
            stall       = !bus.mem_ready;
         end
         T2: begin
            ctrl.mdr_out = 1'b1;
            ctrl.ir_in   = 1'b1;
         end
         T3: begin
            if (is_alu_rr || bus.opcode == OP_ADDI) begin
               ctrl.grb   = 1'b1;
               ctrl.r_out = 1'b1;
               ctrl.y_in  = 1'b1;
            end else if (bus.opcode == OP_LDI || bus.opcode == OP_LD || bus.opcode == OP_ST) begin
               ctrl.grb    = 1'b1;
               ctrl.ba_out = 1'b1;
               ctrl.y_in   = 1'b1;
            end else if (bus.opcode == OP_BR) begin
               ctrl.gra    = 1'b1;
               ctrl.r_out  = 1'b1;
               ctrl.con_in = 1'b1;
            end else if (bus.opcode == OP_JR) begin
               ctrl.gra   = 1'b1;
               ctrl.r_out = 1'b1;
               ctrl.pc_in = 1'b1;
               last_step  = 1'b1;
            end else if (bus.opcode == OP_NOP || bus.opcode == OP_HALT) begin
               last_step = 1'b1;
            end else begin
               ctrl.illegal = 1'b1;
               last_step    = 1'b1;
            end
         end
         T4: begin
            if (is_alu_rr) begin
               ctrl.grc   = 1'b1;
               ctrl.r_out = 1'b1;
               ctrl.z_in  = 1'b1;
               case (bus.opcode)
                  OP_SUB:  ctrl.alu_op = ALU_SUB;
                  OP_AND:  ctrl.alu_op = ALU_AND;
                  OP_OR:   ctrl.alu_op = ALU_OR;
                  default: ctrl.alu_op = ALU_ADD;
               endcase
            end else if (bus.opcode == OP_ADDI || bus.opcode == OP_LDI ||
                         bus.opcode == OP_LD   || bus.opcode == OP_ST) begin
               ctrl.c_out  = 1'b1;
               ctrl.z_in   = 1'b1;
               ctrl.alu_op = ALU_ADD;
            end else if (bus.opcode == OP_BR) begin
               ctrl.pc_out = 1'b1;
               ctrl.y_in   = 1'b1;
            end else begin
               last_step = 1'b1;
            end
         end
         T5: begin
            if (is_alu_rr || bus.opcode == OP_ADDI || bus.opcode == OP_LDI) begin
               ctrl.z_lo_out = 1'b1;
               ctrl.gra      = 1'b1;
               ctrl.r_in     = 1'b1;
               last_step     = 1'b1;
            end else if (bus.opcode == OP_LD || bus.opcode == OP_ST) begin
               ctrl.z_lo_out = 1'b1;
               ctrl.mar_in   = 1'b1;
            end else if (bus.opcode == OP_BR) begin
               ctrl.c_out  = 1'b1;
               ctrl.z_in   = 1'b1;
               ctrl.alu_op = ALU_ADD;
            end else begin
               last_step = 1'b1;
            end
         end
         T6: begin
            if (bus.opcode == OP_LD) begin
               ctrl.read   = 1'b1;
               ctrl.mdr_in = 1'b1;
               stall       = !bus.mem_ready;
            end else if (bus.opcode == OP_ST) begin
               ctrl.gra    = 1'b1;
               ctrl.r_out  = 1'b1;
               ctrl.mdr_in = 1'b1;
            end else if (bus.opcode == OP_BR) begin
               ctrl.z_lo_out = bus.con_ff;
               ctrl.pc_in    = bus.con_ff;
               last_step     = 1'b1;
            end else begin
               last_step = 1'b1;
            end
         end
         T7: begin
            last_step = 1'b1;
            if (bus.opcode == OP_LD) begin
               ctrl.mdr_out = 1'b1;
               ctrl.gra     = 1'b1;
               ctrl.r_in    = 1'b1;
            end else if (bus.opcode == OP_ST) begin
               ctrl.write = 1'b1;
               stall      = !bus.mem_ready;
            end
         end
         default: last_step = 1'b1;
      endcase
   end

   // Reset and halt both force every strobe low without waiting for a clock edge.
   always_comb begin
      ctrl_gated = '0;
      if (reset_n && !halted) begin
         ctrl_gated = ctrl;
      end
   end

   assign bus.gra      = ctrl_gated.gra;
   assign bus.grb      = ctrl_gated.grb;
   assign bus.grc      = ctrl_gated.grc;
   assign bus.rIN      = ctrl_gated.r_in;
   assign bus.rOUT     = ctrl_gated.r_out;
   assign bus.baOUT    = ctrl_gated.ba_out;
   assign bus.pc_out   = ctrl_gated.pc_out;
   assign bus.pc_in    = ctrl_gated.pc_in;
   assign bus.inc_pc   = ctrl_gated.inc_pc;
   assign bus.mar_in   = ctrl_gated.mar_in;
   assign bus.mdr_in   = ctrl_gated.mdr_in;
   assign bus.mdr_out  = ctrl_gated.mdr_out;
   assign bus.ir_in    = ctrl_gated.ir_in;
   assign bus.read     = ctrl_gated.read;
   assign bus.write    = ctrl_gated.write;
   assign bus.y_in     = ctrl_gated.y_in;
   assign bus.z_in     = ctrl_gated.z_in;
   assign bus.z_lo_out = ctrl_gated.z_lo_out;
   assign bus.c_out    = ctrl_gated.c_out;
   assign bus.con_in   = ctrl_gated.con_in;
   assign bus.illegal  = ctrl_gated.illegal;
   assign bus.alu_op   = ctrl_gated.alu_op;
   assign bus.run      = reset_n && !halted;

   // Step counter: advance unless stalled on memory, return to T0 after the last step, freeze once halted.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         step   <= T0;
         halted <= 1'b0;
      end else if (!halted) begin
         if (step == T3 && bus.opcode == OP_HALT) begin
            halted <= 1'b1;
            step   <= T0;
         end else if (!stall) begin
            step <= last_step ? T0 : step_t'(step + 3'd1);
         end
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: each task runs one instruction scenario
// and compares the full strobe set cycle by cycle against hand-derived vectors.
module tb_control_sequencer;

   localparam logic [20:0] GRA      = 21'h100000;
   localparam logic [20:0] GRB      = 21'h080000;
   localparam logic [20:0] GRC      = 21'h040000;
   localparam logic [20:0] RIN      = 21'h020000;
   localparam logic [20:0] ROUT     = 21'h010000;
   localparam logic [20:0] BAOUT    = 21'h008000;
   localparam logic [20:0] PC_OUT   = 21'h004000;
   localparam logic [20:0] PC_IN    = 21'h002000;
   localparam logic [20:0] INC_PC   = 21'h001000;
   localparam logic [20:0] MAR_IN   = 21'h000800;
   localparam logic [20:0] MDR_IN   = 21'h000400;
   localparam logic [20:0] MDR_OUT  = 21'h000200;
   localparam logic [20:0] IR_IN    = 21'h000100;
   localparam logic [20:0] READ     = 21'h000080;
   localparam logic [20:0] WRITE    = 21'h000040;
   localparam logic [20:0] Y_IN     = 21'h000020;
   localparam logic [20:0] Z_IN     = 21'h000010;
   localparam logic [20:0] Z_LO_OUT = 21'h000008;
   localparam logic [20:0] C_OUT    = 21'h000004;
   localparam logic [20:0] CON_IN   = 21'h000002;
   localparam logic [20:0] ILLEGAL  = 21'h000001;
   localparam logic [20:0] NONE     = 21'h000000;

   localparam logic [20:0] F0 = PC_OUT | MAR_IN | INC_PC;
   localparam logic [20:0] F1 = READ | MDR_IN;
   localparam logic [20:0] F2 = MDR_OUT | IR_IN;

   logic clock;
   logic reset_n;
   int   total;
   int   bad;

   control_sequencer_if #(.ALU_W(4)) bus();

   control_sequencer #(.ALU_W(4)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [20:0] strobes();
      return {bus.gra, bus.grb, bus.grc, bus.rIN, bus.rOUT, bus.baOUT,
              bus.pc_out, bus.pc_in, bus.inc_pc, bus.mar_in, bus.mdr_in,
              bus.mdr_out, bus.ir_in, bus.read, bus.write, bus.y_in,
              bus.z_in, bus.z_lo_out, bus.c_out, bus.con_in, bus.illegal};
   endfunction

   task automatic test_reset();
      reset_n       = 1'b0;
      bus.opcode    = 5'b00011;
      bus.con_ff    = 1'b0;
      bus.mem_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      total++;
      if (strobes() !== NONE) begin
         bad++;
         $display("[TB] FAIL reset_strobes got=%h exp=%h", strobes(), NONE);
      end
      total++;
      if (bus.run !== 1'b0 || bus.alu_op !== 4'b0000) begin
         bad++;
         $display("[TB] FAIL reset_run_alu got run=%b alu=%b exp run=0 alu=0000", bus.run, bus.alu_op);
      end
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      total++;
      if (bus.run !== 1'b1 || strobes() !== F0) begin
         bad++;
         $display("[TB] FAIL reset_release got run=%b strobes=%h exp run=1 strobes=%h", bus.run, strobes(), F0);
      end
   endtask

   task automatic test_add();
      logic [20:0] exp_v [0:6];
      exp_v = '{F0, F1, F2, GRB | ROUT | Y_IN, GRC | ROUT | Z_IN, Z_LO_OUT | GRA | RIN, F0};
      bus.opcode    = 5'b00011;
      bus.mem_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         #1;
         total++;
         if (strobes() !== exp_v[i]) begin
            bad++;
            $display("[TB] FAIL add_step%0d got=%h exp=%h", i, strobes(), exp_v[i]);
         end
         total++;
         if (bus.run !== 1'b1) begin
            bad++;
            $display("[TB] FAIL add_run%0d got=%b exp=1", i, bus.run);
         end
         if (i == 4) begin
            total++;
            if (bus.alu_op !== 4'b0000) begin
               bad++;
               $display("[TB] FAIL add_alu_op got=%b exp=0000", bus.alu_op);
            end
         end
         if (i < 6) begin
            @(posedge clock);
            #1;
         end
      end
   endtask

   task automatic test_alu_ops();
      logic [4:0]  ops  [0:3];
      logic [3:0]  alus [0:3];
      logic [20:0] t3   [0:3];
      logic [20:0] t4   [0:3];
      ops  = '{5'b00100, 5'b00101, 5'b00110, 5'b01100};
      alus = '{4'b0001, 4'b0010, 4'b0011, 4'b0000};
      t3   = '{GRB | ROUT | Y_IN, GRB | ROUT | Y_IN, GRB | ROUT | Y_IN, GRB | ROUT | Y_IN};
      t4   = '{GRC | ROUT | Z_IN, GRC | ROUT | Z_IN, GRC | ROUT | Z_IN, C_OUT | Z_IN};
      bus.mem_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus.opcode = ops[k];
         for (int i = 0; i < 6; i++) begin
            #1;
            if (i == 3) begin
               total++;
               if (strobes() !== t3[k]) begin
                  bad++;
                  $display("[TB] FAIL alu%0d_t3 got=%h exp=%h", k, strobes(), t3[k]);
               end
            end
            if (i == 4) begin
               total++;
               if (strobes() !== t4[k] || bus.alu_op !== alus[k]) begin
                  bad++;
                  $display("[TB] FAIL alu%0d_t4 got=%h/%b exp=%h/%b", k, strobes(), bus.alu_op, t4[k], alus[k]);
               end
            end
            if (i == 5) begin
               total++;
               if (strobes() !== (Z_LO_OUT | GRA | RIN)) begin
                  bad++;
                  $display("[TB] FAIL alu%0d_t5 got=%h exp=%h", k, strobes(), Z_LO_OUT | GRA | RIN);
               end
            end
            @(posedge clock);
            #1;
         end
      end
   endtask

   task automatic test_ld_stall();
      logic        mr    [0:11];
      logic [20:0] exp_v [0:11];
      mr    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      exp_v = '{F0, F1, F2, GRB | BAOUT | Y_IN, C_OUT | Z_IN, Z_LO_OUT | MAR_IN,
                F1, F1, F1, F1, MDR_OUT | GRA | RIN, F0};
      bus.opcode = 5'b00000;
      for (int i = 0; i < 12; i++) begin
         bus.mem_ready = mr[i];
         #1;
         total++;
         if (strobes() !== exp_v[i]) begin
            bad++;
            $display("[TB] FAIL ld_cycle%0d got=%h exp=%h", i, strobes(), exp_v[i]);
         end
         if (i < 11) begin
            @(posedge clock);
            #1;
         end
      end
   endtask

   task automatic test_br();
      logic [20:0] exp_v [0:7];
      bus.opcode    = 5'b10010;
      bus.mem_ready = 1'b1;
      for (int c = 0; c < 2; c++) begin
         bus.con_ff = c[0];
         exp_v = '{F0, F1, F2, GRA | ROUT | CON_IN, PC_OUT | Y_IN, C_OUT | Z_IN,
                   (c == 1) ? (Z_LO_OUT | PC_IN) : NONE, F0};
         for (int i = 0; i < 8; i++) begin
            #1;
            total++;
            if (strobes() !== exp_v[i]) begin
               bad++;
               $display("[TB] FAIL br_con%0d_cycle%0d got=%h exp=%h", c, i, strobes(), exp_v[i]);
            end
            if (i < 7) begin
               @(posedge clock);
               #1;
            end
         end
      end
      bus.con_ff = 1'b0;
   endtask

   task automatic test_illegal();
      logic [20:0] exp_v [0:4];
      exp_v = '{F0, F1, F2, ILLEGAL, F0};
      bus.opcode    = 5'b11111;
      bus.mem_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         total++;
         if (strobes() !== exp_v[i]) begin
            bad++;
            $display("[TB] FAIL illegal_cycle%0d got=%h exp=%h", i, strobes(), exp_v[i]);
         end
         if (i < 4) begin
            @(posedge clock);
            #1;
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0]  ops   [0:9];
      logic        mr    [0:9];
      logic [20:0] exp_v [0:9];
      ops   = '{5'b11010, 5'b11010, 5'b11010, 5'b11010, 5'b11010,
                5'b10011, 5'b10011, 5'b10011, 5'b10011, 5'b10011};
      mr    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      exp_v = '{F0, F1, F1, F2, NONE, F0, F1, F2, GRA | ROUT | PC_IN, F0};
      for (int i = 0; i < 10; i++) begin
         bus.opcode    = ops[i];
         bus.mem_ready = mr[i];
         #1;
         total++;
         if (strobes() !== exp_v[i]) begin
            bad++;
            $display("[TB] FAIL b2b_cycle%0d got=%h exp=%h", i, strobes(), exp_v[i]);
         end
         if (i < 9) begin
            @(posedge clock);
            #1;
         end
      end
   endtask

   task automatic test_halt();
      logic [20:0] exp_v [0:3];
      exp_v = '{F0, F1, F2, NONE};
      bus.opcode    = 5'b11011;
      bus.mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++;
         if (strobes() !== exp_v[i] || bus.run !== 1'b1) begin
            bad++;
            $display("[TB] FAIL halt_fetch%0d got=%h run=%b exp=%h run=1", i, strobes(), bus.run, exp_v[i]);
         end
         @(posedge clock);
         #1;
      end
      for (int i = 0; i < 20; i++) begin
         bus.mem_ready = i[0];
         #1;
         total++;
         if (strobes() !== NONE || bus.run !== 1'b0 || bus.alu_op !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL halted_cycle%0d got=%h run=%b exp=%h run=0", i, strobes(), bus.run, NONE);
         end
         @(posedge clock);
         #1;
      end
      bus.mem_ready = 1'b1;
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      bus.opcode = 5'b11010;
      #1;
      total++;
      if (strobes() !== F0 || bus.run !== 1'b1) begin
         bad++;
         $display("[TB] FAIL halt_recover got=%h run=%b exp=%h run=1", strobes(), bus.run, F0);
      end
      exp_v = '{F1, F2, NONE, F0};
      for (int i = 0; i < 4; i++) begin
         @(posedge clock);
         #1;
         total++;
         if (strobes() !== exp_v[i] || bus.run !== 1'b1) begin
            bad++;
            $display("[TB] FAIL halt_refetch%0d got=%h run=%b exp=%h run=1", i, strobes(), bus.run, exp_v[i]);
         end
      end
   endtask

   task automatic test_st_reset();
      logic        mr    [0:8];
      logic [20:0] exp_v [0:8];
      mr    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      exp_v = '{F0, F1, F2, GRB | BAOUT | Y_IN, C_OUT | Z_IN, Z_LO_OUT | MAR_IN,
                GRA | ROUT | MDR_IN, WRITE, WRITE};
      bus.opcode = 5'b00010;
      for (int i = 0; i < 9; i++) begin
         bus.mem_ready = mr[i];
         #1;
         total++;
         if (strobes() !== exp_v[i]) begin
            bad++;
            $display("[TB] FAIL st_cycle%0d got=%h exp=%h", i, strobes(), exp_v[i]);
         end
         if (i < 8) begin
            @(posedge clock);
            #1;
         end
      end
      reset_n = 1'b0;
      #1;
      total++;
      if (strobes() !== NONE || bus.run !== 1'b0) begin
         bad++;
         $display("[TB] FAIL st_reset_drop got=%h run=%b exp=%h run=0", strobes(), bus.run, NONE);
      end
      #1;
      reset_n = 1'b1;
      bus.mem_ready = 1'b1;
      #1;
      total++;
      if (strobes() !== F0 || bus.run !== 1'b1) begin
         bad++;
         $display("[TB] FAIL st_reset_t0 got=%h run=%b exp=%h run=1", strobes(), bus.run, F0);
      end
      @(posedge clock);
      #1;
      total++;
      if (strobes() !== F1) begin
         bad++;
         $display("[TB] FAIL st_reset_t1 got=%h exp=%h", strobes(), F1);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_add();
      test_alu_ops();
      test_ld_stall();
      test_br();
      test_illegal();
      test_back_to_back();
      test_halt();
      test_st_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
